aes_inv_key_sched: RTL and testbench
====================================

Name: aes_inv_key_sched

Overview:
Iterative AES-128 key-schedule engine that serves round keys in descending order (round 10 down to round 0) for the decryption datapath.
- On start it runs the forward expansion from the master key to reach the round-10 key.
- It then walks the schedule backwards one round per consumer request, using the inverse key recurrence, so no 11-entry key RAM is needed.
- It sits between the master-key register and the cipher core's I_AddRoundKey stage, replacing per-round forward recomputation.

Parameters:
NR, 10, number of AES-128 rounds; fixed for AES-128, exposed only for bench readability.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset: synchronous, active-high (port name retained per codebase convention; asserted = 1 clears block)
start  input  1  pulse; begin a new schedule using key_in
key_in  input  128  master key, byte 0 at [127:120]; sampled only on accepted start
key_next  input  1  consumer request for the next-lower round key
busy  output  1  high from accepted start until final handshake
key_valid  output  1  round_key_o/round_o are valid
round_key_o  output  128  current round key, word 0 at [127:96]
round_o  output  4  index of round_key_o (10..0)
last  output  1  key_valid && round_o==0 (combinational)

Behaviour:
- Reset (rst_n=1 at a clock edge): state=IDLE; busy=0, key_valid=0, round_key_o=0, round_o=0, last=0; internal words and rcon index cleared. This overrides any in-flight operation.
- Internal register: w0..w3 (32 b each); round_key_o = {w0,w1,w2,w3}.
- Rcon ROM indexed 1..10: 01,02,04,08,10,20,40,80,1b,36, placed in bits [31:24] of the word.
- SubWord uses four S-box instances in forward mode only (inv_en tied 0). RotWord(a,b,c,d) = (b,c,d,a).
- FSM states: IDLE, EXPAND, SERVE.
- IDLE:
  - start=1 latches key_in into w, sets cnt=1 and busy=1, and moves to EXPAND.
  - key_next is ignored.
- EXPAND: each cycle computes forward round key cnt from the round cnt-1 key:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon[cnt]
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - cnt increments each cycle. On the cycle with cnt==10, go to SERVE with round_o=10 and key_valid=1.
  - Latency: start accepted at edge T → key_valid=1 and round-10 key visible after edge T+10.
  - key_valid stays 0 throughout EXPAND; key_next is ignored.
- SERVE: key_valid=1 and the outputs hold steady until handshake (key_valid && key_next at an edge).
  - Handshake with round_o=r>0: load the round r-1 key at the same edge; round_o=r-1; key_valid stays 1. One key per cycle is sustainable.
    - w3' = w3 ^ w2
    - w2' = w2 ^ w1
    - w1' = w1 ^ w0
    - w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon[r]
  - Handshake with round_o=0: return to IDLE; key_valid=0, busy=0, round_o=0. round_key_o holds the master key until the next start.
- start while busy=1 is ignored (no restart, key_in not sampled).
- Simultaneous start and final handshake in the same cycle: start is ignored; a new start is required in IDLE.
- All arithmetic is GF(2) XOR. Rcon index never leaves 1..10, and round_o never wraps below 0.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse at edge T → busy=1 at T; key_valid=1 after T+10 with round_o=10 and round_key_o=d014f9a8c9ee2589e13f0cc8b6630ca6.
2. Continuing 1, hold key_next=1 for 10 cycles:
   - round 9 = ac7766f319fadc2128d12941575c006e
   - round 1 = a0fafe1788542cb123a339392a6c7605
   - round 0 = 2b7e151628aed2a6abf7158809cf4f3c, with last=1
   - one more handshake → key_valid=0, busy=0.
3. Zero key 00..00 → round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
   - Insert random key_next gaps; outputs must hold stable while key_next=0.
   - The sequence must match a forward-expansion model reversed.
4. Pulse start (with a different key_in) during EXPAND and again during SERVE → ignored; the key sequence from scenario 1 is unchanged.
5. Assert rst_n=1 for one cycle mid-SERVE at round_o=5 → next cycle busy=0, key_valid=0, round_key_o=0, round_o=0. A subsequent start reproduces scenario 1 exactly.
6. key_next=1 held while in IDLE and during EXPAND → no state change; round_o stays 0 until SERVE, then exactly one decrement per handshake cycle.

Source files
------------

// File: rtl/aes_inv_key_sched.sv
// AES-128 key schedule that serves round keys from round 10 down to round 0.
// It expands forward to round 10 once, then rewinds one round per consumer request.

module aes_sbox (
    input  logic [7:0] in_byte,
    input  logic       inv_en,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 gives the multiplicative inverse and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    always_comb begin
        if (inv_en) out_byte = gf_inv(inv_affine(in_byte));
        else        out_byte = affine(gf_inv(in_byte));
    end
endmodule

module aes_inv_key_sched #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_next,
    output logic         busy,
    output logic         key_valid,
    output logic [127:0] round_key_o,
    output logic [3:0]   round_o,
    output logic         last
);
    typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [3:0]  round_q, round_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] w0_q, w1_q, w2_q, w3_q;
    logic [31:0] w0_d, w1_d, w2_d, w3_d;

    logic [3:0]  rcon_idx;
    logic [7:0]  rcon;
    logic [31:0] w3_back, sub_src, rot_w, sub_w;
    logic [31:0] fw0, fw1, fw2, fw3;
    logic [31:0] bw0, bw1, bw2;

    always_comb begin
        rcon_idx = (state_q == SERVE) ? round_q : cnt_q;
        case (rcon_idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // The S-boxes are shared: forward steps substitute w3, backward steps the recovered w3.
    assign w3_back = w3_q ^ w2_q;
    assign sub_src = (state_q == SERVE) ? w3_back : w3_q;
    assign rot_w   = {sub_src[23:0], sub_src[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte (rot_w[8*i +: 8]),
            .inv_en  (1'b0),
            .out_byte(sub_w[8*i +: 8])
        );
    end

    assign fw0 = w0_q ^ sub_w ^ {rcon, 24'h0};
    assign fw1 = w1_q ^ fw0;
    assign fw2 = w2_q ^ fw1;
    assign fw3 = w3_q ^ fw2;

    assign bw0 = w0_q ^ sub_w ^ {rcon, 24'h0};
    assign bw1 = w1_q ^ w0_q;
    assign bw2 = w2_q ^ w1_q;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    {w0_d, w1_d, w2_d, w3_d} = key_in;
                    cnt_d   = 4'd1;
                    busy_d  = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                {w0_d, w1_d, w2_d, w3_d} = {fw0, fw1, fw2, fw3};
                if (cnt_q == LAST_RND) begin
                    state_d = SERVE;
                    round_d = LAST_RND;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SERVE: begin
                if (key_next) begin
                    if (round_q != 4'd0) begin
                        {w0_d, w1_d, w2_d, w3_d} = {bw0, bw1, bw2, w3_back};
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            round_q <= 4'd0;
            cnt_q   <= 4'd0;
            w0_q    <= 32'h0;
            w1_q    <= 32'h0;
            w2_q    <= 32'h0;
            w3_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
        end
    end

    assign busy        = busy_q;
    assign key_valid   = valid_q;
    assign round_o     = round_q;
    assign round_key_o = {w0_q, w1_q, w2_q, w3_q};
    assign last        = valid_q && (round_q == 4'd0);
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for the descending AES-128 key schedule: known FIPS-197 vectors plus
// random keys checked against a table-based forward expansion, reversed.

module tb_aes_inv_key_sched;
    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         key_next;
    logic         busy;
    logic         key_valid;
    logic [127:0] round_key_o;
    logic [3:0]   round_o;
    logic         last;

    aes_inv_key_sched #(.NR(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .key_next   (key_next),
        .busy       (busy),
        .key_valid  (key_valid),
        .round_key_o(round_key_o),
        .round_o    (round_o),
        .last       (last)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [2047:0] sbox_tab = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic [127:0] mk [0:10];
    logic [127:0] cap [0:10];

    function automatic logic [7:0] sb(input logic [7:0] x);
        return sbox_tab[(255 - int'(x)) * 8 +: 8];
    endfunction

    // Plain FIPS-197 KeyExpansion into a 44-word array, regrouped per round.
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_schedule(input logic [127:0] key, input bit gaps, input bit hold,
                                input bit inject);
        int lat;
        int n;
        bit moved;
        expand(key);
        key_next = hold;
        key_in   = key;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("valid_after_start", key_valid, 0);
        lat   = 0;
        moved = 0;
        while (!key_valid && lat < 20) begin
            if (round_o != 0) moved = 1;
            if (inject && lat == 3) begin
                key_in = rand_key();
                start  = 1'b1;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        chk("start_latency", lat, 10);
        if (hold) chk("round_zero_in_expand", moved, 0);
        if (!key_valid) begin
            key_next = 1'b0;
            return;
        end
        for (int r = 10; r >= 0; r--) begin
            chk("round_o", round_o, r);
            chk("round_key", round_key_o, mk[r]);
            chk("last", last, (r == 0));
            cap[r] = round_key_o;
            if (gaps) begin
                key_next = 1'b0;
                n = $urandom_range(0, 3);
                repeat (n) begin
                    tick();
                    chk("gap_round_key", round_key_o, mk[r]);
                    chk("gap_round_o", round_o, r);
                end
            end
            key_next = 1'b1;
            if (inject && (r == 5 || r == 0)) begin
                key_in = rand_key();
                start  = 1'b1;
            end
            tick();
            start = 1'b0;
            if (!hold) key_next = 1'b0;
        end
        chk("final_valid", key_valid, 0);
        chk("final_busy", busy, 0);
        chk("final_round", round_o, 0);
        chk("final_key_holds_master", round_key_o, key);
        if (inject) begin
            tick();
            chk("start_on_final_ignored", busy, 0);
        end
        key_next = 1'b0;
    endtask

    typedef struct {
        logic [127:0] key;
        int           round;
        logic [127:0] exp;
    } vec_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{FIPS_KEY, 9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[2] = '{FIPS_KEY, 1,  128'ha0fafe1788542cb123a339392a6c7605};
        vecs[3] = '{FIPS_KEY, 0,  FIPS_KEY};
        vecs[4] = '{128'h0,   10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vecs[5] = '{128'h0,   0,  128'h0};

        rst_n    = 1'b1;
        start    = 1'b0;
        key_in   = '0;
        key_next = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_valid", key_valid, 0);
        chk("reset_key", round_key_o, 0);
        chk("reset_round", round_o, 0);
        chk("reset_last", last, 0);

        // Known-answer vectors; zero key runs with random consumer gaps.
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || vecs[i].key != vecs[i-1].key)
                run_schedule(vecs[i].key, (i >= 4), 1'b0, 1'b0);
            chk("vector_table", cap[vecs[i].round], vecs[i].exp);
        end

        // Starts during EXPAND, during SERVE and on the final handshake are ignored.
        run_schedule(FIPS_KEY, 1'b0, 1'b0, 1'b1);
        chk("inject_round10", cap[10], vecs[0].exp);

        // Reset in the middle of serving at round 5.
        expand(FIPS_KEY);
        key_in = FIPS_KEY;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && !key_valid; i++) tick();
        key_next = 1'b1;
        for (int i = 0; i < 20 && round_o != 5; i++) tick();
        key_next = 1'b0;
        chk("pre_reset_round", round_o, 5);
        chk("pre_reset_key", round_key_o, mk[5]);
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        chk("midreset_busy", busy, 0);
        chk("midreset_valid", key_valid, 0);
        chk("midreset_key", round_key_o, 0);
        chk("midreset_round", round_o, 0);
        run_schedule(FIPS_KEY, 1'b0, 1'b0, 1'b0);

        // key_next held high in IDLE, through EXPAND and through SERVE.
        key_next = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_next_busy", busy, 0);
            chk("idle_next_round", round_o, 0);
            chk("idle_next_valid", key_valid, 0);
        end
        run_schedule(FIPS_KEY, 1'b0, 1'b1, 1'b0);

        // Random keys with random consumer back-pressure.
        repeat (6) run_schedule(rand_key(), 1'b1, 1'b0, 1'b0);
        run_schedule(rand_key(), 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
